// File: rtl/prim_reg_bus_pkg.sv
// Shared types for the register bus adapter: FSM state, registered request/response
// flags and the byte-address to word-index helper.
package prim_reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } reg_bus_state_e;

  // Control part of the accepted request; index and data stay width-parameterised in the top.
  typedef struct packed {
    logic we;
    logic err;
  } reg_bus_req_t;

  typedef struct packed {
    logic valid;
    logic err;
  } reg_bus_rsp_t;

  function automatic logic [31:0] addr_to_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/prim_reg_bus_decode.sv
// Combinational request check: word index plus error flag (misalignment, out-of-range,
// partial write, and write parity when PRIM_REG_BUS_PARITY_EN is defined).
module prim_reg_bus_decode
  import prim_reg_bus_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 8,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned IW      = AW - 2,
  localparam int unsigned BW      = DW / 8
) (
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [BW-1:0] be_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [BW-1:0] wpar_i,
  output logic [IW-1:0] index_o,
  output logic          err_o
);

  logic par_err;

`ifdef PRIM_REG_BUS_PARITY_EN
  // Each byte plus its parity bit must have odd weight; only writes are checked.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    par_err = 1'b0;
    for (int b = 0; b < int'(BW); b++) begin
      if (we_i && !(^{wdata_i[b*8 +: 8], wpar_i[b]})) par_err = 1'b1;
    end
  end
`else
  logic unused_wpar;
  assign unused_wpar = ^{wpar_i, wdata_i};
  assign par_err     = 1'b0;
`endif

  assign index_o = IW'(addr_to_index(32'(addr_i)));

  assign err_o = (addr_i[1:0] != 2'b00)
               || (addr_to_index(32'(addr_i)) >= 32'(NUM_REGS))
               || (we_i && (be_i != '1))
               || par_err;

endmodule

// File: rtl/prim_reg_bus_adapter.sv
// Valid/ready bus to one-cycle per-register strobes with a registered response.
// Optional write-parity checking is enabled by defining PRIM_REG_BUS_PARITY_EN.
module prim_reg_bus_adapter
  import prim_reg_bus_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 8,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned IW      = AW - 2,
  localparam int unsigned BW      = DW / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [AW-1:0]          req_addr_i,
  input  logic [DW-1:0]          req_wdata_i,
  input  logic [BW-1:0]          req_be_i,
  input  logic [BW-1:0]          req_wpar_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DW-1:0]          rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [NUM_REGS-1:0]    reg_we_o,
  output logic [NUM_REGS-1:0]    reg_re_o,
  output logic [DW-1:0]          reg_wd_o,
  input  logic [NUM_REGS*DW-1:0] reg_rdata_i
);

  reg_bus_state_e      state_q;
  reg_bus_req_t        req_q;
  reg_bus_rsp_t        rsp_q;
  logic [IW-1:0]       idx_q;
  logic [DW-1:0]       rsp_rdata_q;
  logic [NUM_REGS-1:0] reg_we_q;
  logic [NUM_REGS-1:0] reg_re_q;
  logic [DW-1:0]       reg_wd_q;

  logic [IW-1:0]       dec_index;
  logic                dec_err;
  logic [NUM_REGS-1:0] dec_onehot;
  logic [DW-1:0]       sel_rdata;

  prim_reg_bus_decode #(
    .DW       (DW),
    .AW       (AW),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .we_i    (req_we_i),
    .addr_i  (req_addr_i),
    .be_i    (req_be_i),
    .wdata_i (req_wdata_i),
    .wpar_i  (req_wpar_i),
    .index_o (dec_index),
    .err_o   (dec_err)
  );

  assign dec_onehot = NUM_REGS'(1) << dec_index;

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (idx_q == IW'(k)) sel_rdata = reg_rdata_i[k*DW +: DW];
    end
  end

  // Strobes are registered at accept so they appear exactly in the ACCESS cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: data registers are reset too, so every output reads 0 after reset.
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      idx_q       <= '0;
      rsp_rdata_q <= '0;
      reg_we_q    <= '0;
      reg_re_q    <= '0;
      reg_wd_q    <= '0;
    end else begin
      // NOTE: non-blocking defaults here; a later assignment in the case overrides them.
      reg_we_q <= '0;
      reg_re_q <= '0;
      reg_wd_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_q.we  <= req_we_i;
            req_q.err <= dec_err;
            idx_q     <= dec_index;
            if (!dec_err) begin
              if (req_we_i) begin
                reg_we_q <= dec_onehot;
                reg_wd_q <= req_wdata_i;
              end else begin
                reg_re_q <= dec_onehot;
              end
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Sampled at the strobe edge, so read-to-clear fields return pre-clear data.
          rsp_rdata_q <= (!req_q.we && !req_q.err) ? sel_rdata : '0;
          rsp_q.valid <= 1'b1;
          rsp_q.err   <= req_q.err;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_q       <= '0;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = rsp_q.valid;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_rdata_o = rsp_rdata_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign reg_wd_o    = reg_wd_q;

endmodule

// File: tb/tb_prim_reg_bus_adapter.sv
// Scoreboard bench for prim_reg_bus_adapter: a word-array register model predicts
// strobes and responses; independent monitors compare what the DUT presents.
module tb_prim_reg_bus_adapter;

  localparam int DW     = 32;
  localparam int AW     = 8;
  localparam int NR     = 16;
  localparam int BW     = DW / 8;
  localparam int RC_IDX = 5;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic             req_we_i = 1'b0;
  logic [AW-1:0]    req_addr_i = '0;
  logic [DW-1:0]    req_wdata_i = '0;
  logic [BW-1:0]    req_be_i = '0;
  logic [BW-1:0]    req_wpar_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [DW-1:0]    rsp_rdata_o;
  logic             rsp_err_o;
  logic [NR-1:0]    reg_we_o;
  logic [NR-1:0]    reg_re_o;
  logic [DW-1:0]    reg_wd_o;
  logic [NR*DW-1:0] reg_rdata_i;

  prim_reg_bus_adapter #(.DW(DW), .AW(AW), .NUM_REGS(NR)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .req_wpar_i  (req_wpar_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_wd_o    (reg_wd_o),
    .reg_rdata_i (reg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NR-1:0] we;
    logic [NR-1:0] re;
    logic [DW-1:0] wd;
    int            cyc;
  } strb_exp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } rsp_exp_t;

  strb_exp_t     strb_q[$];
  rsp_exp_t      rsp_q[$];
  logic [DW-1:0] ref_mem [NR];
  logic [DW-1:0] env_mem [NR];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            last_acc = 0;
  int            hs_cyc = 0;
  int            bp_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Register block stand-in: plain storage plus one read-to-clear word.
  always_comb begin
    for (int k = 0; k < NR; k++) reg_rdata_i[k*DW +: DW] = env_mem[k];
  end

  always @(posedge clk_i) begin
    for (int k = 0; k < NR; k++) begin
      if (reg_we_o[k]) env_mem[k] <= reg_wd_o;
      else if (k == RC_IDX && reg_re_o[k]) env_mem[k] <= '0;
    end
  end

  always @(posedge clk_i) begin
    #1;
    case (bp_mode)
      0:       rsp_ready_i = 1'b1;
      1:       rsp_ready_i = ($urandom % 3) != 0;
      default: rsp_ready_i = 1'b0;
    endcase
  end

  // Strobe monitor.
  always @(negedge clk_i) begin
    strb_exp_t e;
    if (reg_we_o != '0 || reg_re_o != '0) begin
      if (strb_q.size() == 0) begin
        check("strobe_unexpected", {reg_we_o, reg_re_o}, '0);
      end else begin
        e = strb_q.pop_front();
        check("strobe_we", reg_we_o, e.we);
        check("strobe_re", reg_re_o, e.re);
        check("strobe_wd", reg_wd_o, e.wd);
        check("strobe_cycle", cyc, e.cyc);
      end
    end else begin
      check("wd_zero_without_we", reg_wd_o, '0);
    end
  end

  // Response monitor.
  logic [DW-1:0] prev_rdata;
  logic          prev_err;
  bit            holding = 0;
  always @(negedge clk_i) begin
    rsp_exp_t r;
    if (rst_i) begin
      holding = 0;
    end else if (rsp_valid_o) begin
      if (!holding) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected_valid", rsp_valid_o, 1'b0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_latency", cyc, r.cyc);
          check("rsp_rdata", rsp_rdata_o, r.rdata);
          check("rsp_err", rsp_err_o, r.err);
        end
      end else begin
        check("rsp_rdata_stable", rsp_rdata_o, prev_rdata);
        check("rsp_err_stable", rsp_err_o, prev_err);
      end
      prev_rdata = rsp_rdata_o;
      prev_err   = rsp_err_o;
      holding    = !rsp_ready_i;
      if (rsp_ready_i) hs_cyc = cyc;
    end else begin
      holding = 0;
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [BW-1:0] be, input bit flip_par, input bit push_rsp);
    int            waitc;
    int            idx;
    logic          err;
    logic [DW-1:0] rdata;
    logic [BW-1:0] par;
    strb_exp_t     se;
    rsp_exp_t      re;
    for (int b = 0; b < BW; b++) par[b] = ~^wdata[b*8 +: 8];
    if (flip_par) par[0] = ~par[0];
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    req_wpar_i  = par;
    waitc = 0;
    while (!req_ready_o && waitc < 300) begin
      @(negedge clk_i);
      waitc++;
    end
    check("req_ready_within_bound", req_ready_o, 1'b1);
    if (!req_ready_o) begin
      req_valid_i = 1'b0;
      return;
    end
    idx = int'(addr) / 4;
    err = (int'(addr) % 4 != 0) || (idx >= NR) || (we && be != {BW{1'b1}});
`ifdef PRIM_REG_BUS_PARITY_EN
    if (we) for (int b = 0; b < BW; b++) if (^{wdata[b*8 +: 8], par[b]} == 1'b0) err = 1'b1;
`endif
    rdata = '0;
    if (!err && !we) begin
      rdata = ref_mem[idx];
      if (idx == RC_IDX) ref_mem[idx] = '0;
    end
    if (!err && we) ref_mem[idx] = wdata;
    last_acc = cyc;
    if (!err) begin
      se.we = '0;
      se.re = '0;
      if (we) se.we[idx] = 1'b1;
      else    se.re[idx] = 1'b1;
      se.wd  = we ? wdata : '0;
      se.cyc = cyc + 1;
      strb_q.push_back(se);
    end
    if (push_rsp) begin
      re.rdata = rdata;
      re.err   = err;
      re.cyc   = cyc + 2;
      rsp_q.push_back(re);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || rsp_valid_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_rsp_queue_empty", rsp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int            n;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    bit            we;
    for (int k = 0; k < NR; k++) begin
      ref_mem[k] = $urandom;
      env_mem[k] = ref_mem[k];
    end
    ref_mem[3]      = 32'h1234_5678;
    env_mem[3]      = 32'h1234_5678;
    ref_mem[RC_IDX] = 32'hA5A5_0001;
    env_mem[RC_IDX] = 32'hA5A5_0001;

    // Reset values.
    repeat (3) @(negedge clk_i);
    check("rst_req_ready", req_ready_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_rdata", rsp_rdata_o, '0);
    check("rst_rsp_err", rsp_err_o, 1'b0);
    check("rst_reg_we", reg_we_o, '0);
    check("rst_reg_re", reg_re_o, '0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_req_ready", req_ready_o, 1'b1);

    // Directed accesses.
    issue(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h0C, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h08, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h14, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h14, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h06, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h40, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b1, 8'h10, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b1);
    issue(1'b1, 8'h18, 32'h600D_D00D, 4'hF, 1'b1, 1'b1);
    issue(1'b0, 8'h18, '0, 4'hF, 1'b0, 1'b1);
    issue(1'b0, 8'h10, '0, 4'hF, 1'b0, 1'b1);
    drain();

    // Back-pressure hold: response stays stable and a pending request waits.
    bp_mode = 2;
    issue(1'b0, 8'h0C, '0, 4'hF, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("hold_rsp_valid", rsp_valid_o, 1'b1);
    fork
      issue(1'b1, 8'h1C, 32'hCAFE_0042, 4'hF, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk_i);
          check("hold_req_ready_low", req_ready_o, 1'b0);
        end
        bp_mode = 0;
      end
    join
    check("accept_after_release", last_acc, hs_cyc + 1);
    drain();

    // Reset during ACCESS drops the request.
    issue(1'b0, 8'h24, '0, 4'hF, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_reg_re", reg_re_o, '0);
    check("midrst_reg_we", reg_we_o, '0);
    check("midrst_rsp_valid", rsp_valid_o, 1'b0);
    check("midrst_req_ready", req_ready_o, 1'b0);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("postrst_rsp_valid", rsp_valid_o, 1'b0);
    end

    // Randomised traffic with random back-pressure.
    bp_mode = 1;
    for (int t = 0; t < 200; t++) begin
      n  = $urandom % 10;
      we = $urandom % 2;
      if (n < 7 || n == 9) a = AW'(($urandom % NR) * 4);
      else if (n == 7)     a = AW'(($urandom % NR) * 4 + 1 + $urandom % 3);
      else                 a = AW'(NR * 4 + $urandom % (256 - NR * 4));
      be = ($urandom % 6 == 0) ? BW'($urandom) : {BW{1'b1}};
      issue(we, a, $urandom, be, ($urandom % 8) == 0, 1'b1);
      repeat ($urandom % 3) @(negedge clk_i);
    end
    bp_mode = 0;
    drain();
    repeat (3) @(negedge clk_i);
    check("strobe_queue_empty", strb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
